// File: rtl/gray_pkg.sv
// gray_pkg: shared types for the Gray-code step tracker.
//   state_t : tracker FSM states (no reference / tracking / latched fault)
//   step_t  : classification of a new sample against the reference
package gray_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      UP   = 2'd1,
      DN   = 2'd2,
      ERR  = 2'd3
   } step_t;

endpackage

// File: rtl/gray_step_tracker_gray2bin.sv
// gray2bin: combinational Gray-to-binary converter, inverse of bin2gray.
//   g : Gray-coded word (WIDTH)
//   b : binary word, b[i] = XOR of g[WIDTH-1:i]
module gray2bin #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] g,
   output logic [WIDTH-1:0] b
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      assign b[i] = ^g[WIDTH-1:i];
   end

endmodule

// File: rtl/gray_step_tracker.sv
// gray_step_tracker: samples a Gray-coded position, converts it to binary and
// classifies each sample against the previous one (up / down / none / illegal).
// Keeps a signed position count, a saturating error count, and latches FAULT
// after ERR_LIMIT consecutive illegal jumps.
//   clk, rst_n        : clock, asynchronous active-low reset
//   gray_in, valid_in : Gray sample and its strobe
//   clear             : synchronous clear, wins over valid_in
//   binary_out        : binary of last accepted sample
//   step_up/dn/err    : one-cycle classification pulses
//   position          : signed accumulated steps (wraps)
//   err_count         : total illegal jumps (saturates)
//   locked, fault     : state is TRACK / FAULT
module gray_step_tracker
   import gray_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int POS_W     = 16,
   parameter int ERR_W     = 8,
   parameter int ERR_LIMIT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             valid_in,
   input  logic             clear,
   output logic [WIDTH-1:0] binary_out,
   output logic             step_up,
   output logic             step_dn,
   output logic             step_err,
   output logic [POS_W-1:0] position,
   output logic [ERR_W-1:0] err_count,
   output logic             locked,
   output logic             fault
);

   localparam logic [WIDTH-1:0] D_ONE = WIDTH'(1);
   localparam logic [ERR_W-1:0] LIMIT = ERR_W'(ERR_LIMIT);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] ref_q, ref_d;
   logic [WIDTH-1:0] bin_d;
   logic [POS_W-1:0] pos_d;
   logic [ERR_W-1:0] errc_d;
   logic [ERR_W-1:0] consec_q, consec_d;
   logic             up_d, dn_d, err_d;

   logic [WIDTH-1:0] b_in;
   logic [WIDTH-1:0] delta;
   step_t            cls;

   gray2bin #(.WIDTH(WIDTH)) u_gray2bin (
      .g (gray_in),
      .b (b_in)
   );

   // modular difference makes 15->0 an up step and 0->15 a down step
   assign delta = b_in - ref_q;

   always_comb begin
      if (delta == '0)         cls = NONE;
      else if (delta == D_ONE) cls = UP;
      else if (delta == '1)    cls = DN;
      else                     cls = ERR;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         ref_q      <= '0;
         binary_out <= '0;
         position   <= '0;
         err_count  <= '0;
         consec_q   <= '0;
         step_up    <= 1'b0;
         step_dn    <= 1'b0;
         step_err   <= 1'b0;
      end else begin
         state_q    <= state_d;
         ref_q      <= ref_d;
         binary_out <= bin_d;
         position   <= pos_d;
         err_count  <= errc_d;
         consec_q   <= consec_d;
         step_up    <= up_d;
         step_dn    <= dn_d;
         step_err   <= err_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ref_d    = ref_q;
      bin_d    = binary_out;
      pos_d    = position;
      errc_d   = err_count;
      consec_d = consec_q;
      up_d     = 1'b0;
      dn_d     = 1'b0;
      err_d    = 1'b0;

      if (clear) begin
         state_d  = IDLE;
         ref_d    = '0;
         bin_d    = '0;
         pos_d    = '0;
         errc_d   = '0;
         consec_d = '0;
      end else if (valid_in) begin
         unique case (state_q)
            IDLE: begin
               ref_d   = b_in;
               bin_d   = b_in;
               state_d = TRACK;
            end
            TRACK: begin
               // resync to the new sample even on an illegal jump
               ref_d = b_in;
               bin_d = b_in;
               unique case (cls)
                  NONE: ;
                  UP: begin
                     up_d     = 1'b1;
                     pos_d    = position + POS_W'(1);
                     consec_d = '0;
                  end
                  DN: begin
                     dn_d     = 1'b1;
                     pos_d    = position - POS_W'(1);
                     consec_d = '0;
                  end
                  ERR: begin
                     err_d    = 1'b1;
                     consec_d = consec_q + ERR_W'(1);
                     if (err_count != '1) errc_d = err_count + ERR_W'(1);
                     if (consec_d >= LIMIT) state_d = FAULT;
                  end
                  default: ;
               endcase
            end
            FAULT: ;
            default: state_d = IDLE;
         endcase
      end
   end

   // decoded from the state register only, so no input-to-output path
   assign locked = (state_q == TRACK);
   assign fault  = (state_q == FAULT);

endmodule

// File: tb/tb_gray_step_tracker.sv
// Directed-vector bench for gray_step_tracker. The driver pushes the
// hand-computed expected output set for each issued cycle into a queue; an
// independent monitor pops one entry after each clock edge and compares.
module tb_gray_step_tracker;

   typedef struct packed {
      logic [3:0]  bin;
      logic        up;
      logic        dn;
      logic        err;
      logic [15:0] pos;
      logic [7:0]  errc;
      logic        locked;
      logic        fault;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  gray_in = '0;
   logic        valid_in = 1'b0;
   logic        clear = 1'b0;
   logic [3:0]  binary_out;
   logic        step_up, step_dn, step_err;
   logic [15:0] position;
   logic [7:0]  err_count;
   logic        locked, fault;

   exp_t  exp_q[$];
   string name_q[$];
   int    n_total = 0;
   int    n_pass  = 0;

   gray_step_tracker #(
      .WIDTH(4), .POS_W(16), .ERR_W(8), .ERR_LIMIT(3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .gray_in    (gray_in),
      .valid_in   (valid_in),
      .clear      (clear),
      .binary_out (binary_out),
      .step_up    (step_up),
      .step_dn    (step_dn),
      .step_err   (step_err),
      .position   (position),
      .err_count  (err_count),
      .locked     (locked),
      .fault      (fault)
   );

   always #5 clk = ~clk;

   function automatic exp_t actual();
      exp_t a;
      a.bin    = binary_out;
      a.up     = step_up;
      a.dn     = step_dn;
      a.err    = step_err;
      a.pos    = position;
      a.errc   = err_count;
      a.locked = locked;
      a.fault  = fault;
      return a;
   endfunction

   task automatic compare(input string nm, input exp_t e);
      exp_t a;
      a = actual();
      n_total++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got bin=%h up=%b dn=%b err=%b pos=%h errc=%h lk=%b flt=%b, want bin=%h up=%b dn=%b err=%b pos=%h errc=%h lk=%b flt=%b",
                    nm, a.bin, a.up, a.dn, a.err, a.pos, a.errc, a.locked, a.fault,
                    e.bin, e.up, e.dn, e.err, e.pos, e.errc, e.locked, e.fault);
   endtask

   // drive one cycle at the falling edge and queue its expected result
   task automatic cyc(input string nm, input logic [3:0] g, input logic v, input logic c,
                      input logic [3:0] eb, input logic eu, input logic ed, input logic ee,
                      input logic [15:0] ep, input logic [7:0] ec, input logic el, input logic ef);
      exp_t e;
      @(negedge clk);
      gray_in  = g;
      valid_in = v;
      clear    = c;
      e = '{bin:eb, up:eu, dn:ed, err:ee, pos:ep, errc:ec, locked:el, fault:ef};
      exp_q.push_back(e);
      name_q.push_back(nm);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL drain: %0d entries left, want 0", exp_q.size());
   endtask

   // monitor: one output set per edge while expectations are pending
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) compare(name_q.pop_front(), exp_q.pop_front());
      end
   end

   initial begin
      exp_t z;
      z = '0;
      #12;
      compare("reset", z);
      @(negedge clk);
      rst_n = 1'b1;

      // name          gray   v  c   bin  up dn er pos      errc lk flt
      cyc("relock",    4'b0000,1,0, 4'h0,0,0,0, 16'd0,   8'd0,1,0);
      cyc("up1",       4'b0001,1,0, 4'h1,1,0,0, 16'd1,   8'd0,1,0);
      cyc("up2",       4'b0011,1,0, 4'h2,1,0,0, 16'd2,   8'd0,1,0);
      cyc("up3",       4'b0010,1,0, 4'h3,1,0,0, 16'd3,   8'd0,1,0);
      cyc("novalid",   4'b1111,0,0, 4'h3,0,0,0, 16'd3,   8'd0,1,0);
      cyc("clear1",    4'b0000,0,1, 4'h0,0,0,0, 16'd0,   8'd0,0,0);
      cyc("lock15",    4'b1000,1,0, 4'hF,0,0,0, 16'd0,   8'd0,1,0);
      cyc("wrap_up",   4'b0000,1,0, 4'h0,1,0,0, 16'd1,   8'd0,1,0);
      cyc("wrap_dn",   4'b1000,1,0, 4'hF,0,1,0, 16'd0,   8'd0,1,0);
      cyc("up_to0",    4'b0000,1,0, 4'h0,1,0,0, 16'd1,   8'd0,1,0);
      cyc("err_0to7",  4'b0100,1,0, 4'h7,0,0,1, 16'd1,   8'd1,1,0);
      cyc("dn_7to6",   4'b0101,1,0, 4'h6,0,1,0, 16'd0,   8'd1,1,0);
      cyc("same",      4'b0101,1,0, 4'h6,0,0,0, 16'd0,   8'd1,1,0);
      cyc("clear2",    4'b0000,0,1, 4'h0,0,0,0, 16'd0,   8'd0,0,0);
      cyc("relock2",   4'b0000,1,0, 4'h0,0,0,0, 16'd0,   8'd0,1,0);
      cyc("jump1",     4'b0100,1,0, 4'h7,0,0,1, 16'd0,   8'd1,1,0);
      cyc("same_mid",  4'b0100,1,0, 4'h7,0,0,0, 16'd0,   8'd1,1,0);
      cyc("jump2",     4'b0000,1,0, 4'h0,0,0,1, 16'd0,   8'd2,1,0);
      cyc("jump3",     4'b0100,1,0, 4'h7,0,0,1, 16'd0,   8'd3,0,1);
      cyc("flt_ign1",  4'b0101,1,0, 4'h7,0,0,0, 16'd0,   8'd3,0,1);
      cyc("flt_ign2",  4'b0000,1,0, 4'h7,0,0,0, 16'd0,   8'd3,0,1);
      cyc("clear_flt", 4'b0000,0,1, 4'h0,0,0,0, 16'd0,   8'd0,0,0);
      cyc("clr_vld",   4'b0001,1,1, 4'h0,0,0,0, 16'd0,   8'd0,0,0);
      cyc("relock3",   4'b0001,1,0, 4'h1,0,0,0, 16'd0,   8'd0,1,0);
      cyc("p1",        4'b0011,1,0, 4'h2,1,0,0, 16'd1,   8'd0,1,0);
      cyc("p2",        4'b0010,1,0, 4'h3,1,0,0, 16'd2,   8'd0,1,0);
      cyc("p3",        4'b0110,1,0, 4'h4,1,0,0, 16'd3,   8'd0,1,0);
      cyc("p4",        4'b0111,1,0, 4'h5,1,0,0, 16'd4,   8'd0,1,0);
      cyc("p5",        4'b0101,1,0, 4'h6,1,0,0, 16'd5,   8'd0,1,0);
      cyc("hold_p5",   4'b0101,0,0, 4'h6,0,0,0, 16'd5,   8'd0,1,0);
      drain();

      // asynchronous reset between edges must clear outputs at once
      #2;
      rst_n = 1'b0;
      valid_in = 1'b0;
      #1;
      compare("async_rst", z);
      @(negedge clk);
      rst_n = 1'b1;

      cyc("relock4",   4'b0100,1,0, 4'h7,0,0,0, 16'd0,   8'd0,1,0);
      cyc("dn_neg",    4'b0101,1,0, 4'h6,0,1,0, 16'hFFFF,8'd0,1,0);
      cyc("idle_end",  4'b0000,0,0, 4'h6,0,0,0, 16'hFFFF,8'd0,1,0);
      drain();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
